interface_switch_reader: RTL and testbench
==========================================

# interface_switch_reader

Memory-mapped input peripheral: the read-side counterpart of the LED output interface on the same CPU data bus. Samples 24 board switches and 5 push-buttons, synchronises and debounces them, and latches button presses into sticky flags. The CPU reads levels and flags over the data bus and clears flags by writing. Read data is combinational from registered state, so a single-cycle CPU gets the data in the same cycle.

## Interface
- BASE_ADDR, 32'hFFFF_F100, peripheral base; 16-byte window, addr[31:4] == BASE_ADDR[31:4]
- TICK_DIV, 100000, clk cycles per sample tick (1 kHz at 100 MHz); ≥ 2
- DB_SAMPLES, 4, consecutive differing samples needed to accept a new level; 1..15
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  bus write strobe
- addr  in  32  bus byte address
- data  in  32  bus write data
- sw_in  in  24  raw switch pins, asynchronous
- btn_in  in  5  raw button pins, asynchronous, 1 = pressed
- rdata  out  32  read data, combinational from addr and internal registers

## Operation
- Register map, offset = addr[3:2]:
  - 0x0 SW: rdata = {8'h0, sw_stable[23:0]}; read-only.
  - 0x4 BTN: rdata = {27'h0, btn_stable[4:0]}; read-only.
  - 0x8 PRESS: rdata = {27'h0, press_flag[4:0]}; write-1-to-clear on data[4:0].
  - 0xC: reads 0; writes ignored.
- Outside the window: rdata = 0; writes ignored. Writes to 0x0 and 0x4 have no effect.
- Synchroniser: two flops per input bit (29 bits). Reset value 0.
- Tick: free-running counter 0..TICK_DIV-1. tick = 1 for one cycle when the counter wraps.
- Debounce, per bit, evaluated only on tick:
  - sync == stable → cnt ← 0.
  - sync != stable and cnt == DB_SAMPLES-1 → stable ← sync, cnt ← 0.
  - otherwise → cnt ← cnt+1.
  - Any sample equal to stable restarts the count. A glitch shorter than DB_SAMPLES ticks never reaches stable.
- Press detect: btn_prev ← btn_stable each cycle. rise = btn_stable & ~btn_prev sets press_flag bit.
- Clear: we && in window && offset 0x8 clears press_flag bits where data[i] = 1.
- Set and clear of the same bit in the same cycle: set wins, flag stays 1.
- Release (falling edge) does not affect press_flag.

## Timing
- Reset (async assert, sync release): sync flops, stable, cnt, tick counter, btn_prev and press_flag all 0. rdata = 0 for every in-window read while reset is held.
- Input to stable latency: 2 clk (sync), then DB_SAMPLES ticks after the first differing sample. That is at most 2 + DB_SAMPLES·TICK_DIV clk, and at least 2 + (DB_SAMPLES-1)·TICK_DIV + 1 clk.
- press_flag rises 1 clk after btn_stable rises.
- Clear takes effect at the clock edge ending the write cycle. A read in the next cycle sees 0.
- Reads have no side effects. rdata changes in the same cycle as addr.
- Inputs already high at reset release: stable becomes 1 after the normal debounce latency. This counts as a rise, so buttons held at reset release set press_flag.
- Reset mid-count discards all partial debounce counts and flags.

## Structure
- Shared package iface_pkg:
  - offset constants OFF_SW = 2'd0, OFF_BTN = 2'd1, OFF_PRESS = 2'd2
  - widths SW_W = 24, BTN_W = 5
  - the same BASE_ADDR constants used by the LED interface
- Sub-module debounce_cell (parameter W, DB_SAMPLES):
  - contains the synchroniser, per-bit counters and stable register
  - takes clk, rst_n, tick and raw[W-1:0]
  - instantiated twice (W = 24, W = 5)
- The top level holds the tick divider, press logic and bus decode.

## Test plan
Run with TICK_DIV = 4, DB_SAMPLES = 3.
- Reset/idle: hold rst_n = 0 with sw_in = 24'hFFFFFF. Read 0x0 → 0. Release reset; after ≤ 2+12 clk, read 0x0 → 32'h00FFFFFF.
- Glitch reject: sw_in[0] pulses high for 2 ticks then low → SW stays 0. A 3-tick pulse → bit 0 reads 1, then returns to 0 three ticks after release.
- Press sticky: btn_in = 5'b00100 held 4 ticks, then released. Read BTN → 5'b00100 while held, 0 after release. Read PRESS → 5'b00100 and it remains set.
- Clear: write data = 32'h4 to 0x8 → next read of PRESS = 0. Write data = 32'h1 while only bit 2 is set → PRESS still 5'b00100.
- Simultaneous: time a clear of bit 3 on the same cycle as the btn_stable[3] rise → PRESS[3] = 1 afterwards.
- Decode: read BASE_ADDR+0xC → 0. Read BASE_ADDR+0x10 → 0. Write 32'hFFFFFFFF to 0x0 → SW value unchanged.

Source files
------------

// File: rtl/iface_pkg.sv
// Shared constants for the memory-mapped board I/O peripherals on the CPU data bus.
// Holds the register offsets, field widths, base address and the address window decode.
package iface_pkg;

    localparam logic [31:0] SW_BASE_ADDR = 32'hFFFF_F100;

    localparam logic [1:0] OFF_SW    = 2'd0;
    localparam logic [1:0] OFF_BTN   = 2'd1;
    localparam logic [1:0] OFF_PRESS = 2'd2;

    localparam int SW_W  = 24;
    localparam int BTN_W = 5;

    // Each peripheral decodes a 16-byte window aligned on its base.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return (addr[31:4] == base[31:4]);
    endfunction

endpackage

// File: rtl/interface_switch_reader_if.sv
// CPU data bus as seen by a memory-mapped peripheral.
// Read data is returned combinationally in the same cycle as the address.
interface interface_switch_reader_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;

    modport master (output we, output addr, output data, input  rdata);
    modport slave  (input  we, input  addr, input  data, output rdata);
endinterface

// File: rtl/debounce_cell.sv
// Two-flop synchroniser plus per-bit debouncer, sampled on a shared tick.
// A new level is accepted only after DB_SAMPLES consecutive differing samples.
module debounce_cell #(
    parameter int W          = 1,
    parameter int DB_SAMPLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);

    localparam int          CW      = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_SAMPLES - 1);

    logic [W-1:0]  sync1_r;
    logic [W-1:0]  sync2_r;
    logic [W-1:0]  stable_r;
    logic [CW-1:0] cnt_r [W];

    // Synchronise raw pins and advance the per-bit debounce counters on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= '0;
            sync2_r  <= '0;
            stable_r <= '0;
            for (int i = 0; i < W; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (tick) begin
                for (int i = 0; i < W; i++) begin
                    if (sync2_r[i] == stable_r[i]) begin
                        cnt_r[i] <= '0;
                    end else if (cnt_r[i] == CNT_LAST) begin
                        stable_r[i] <= sync2_r[i];
                        cnt_r[i]    <= '0;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + 4'd1;
                    end
                end
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/interface_switch_reader.sv
// Switch / push-button input peripheral: debounced levels plus sticky press flags,
// read over the CPU data bus; press flags are write-1-to-clear.
module interface_switch_reader
    import iface_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = SW_BASE_ADDR,
    parameter int          TICK_DIV   = 100000,
    parameter int          DB_SAMPLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    interface_switch_reader_if.slave       bus,
    input  logic [SW_W-1:0]                sw_in,
    input  logic [BTN_W-1:0]               btn_in
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic [SW_W-1:0]  sw_stable_s;
    logic [BTN_W-1:0] btn_stable_s;
    logic [BTN_W-1:0] btn_prev_r;
    logic [BTN_W-1:0] press_r;
    logic [BTN_W-1:0] rise_s;
    logic [BTN_W-1:0] clear_s;
    logic             win_s;
    logic [1:0]       off_s;
    logic [31:0]      rdata_s;
    logic             unused_s;

    // Free-running sample-tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
        end else if (div_r == DIV_LAST) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick_s = (div_r == DIV_LAST);

    debounce_cell #(.W(SW_W), .DB_SAMPLES(DB_SAMPLES)) u_sw_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick_s),
        .raw    (sw_in),
        .stable (sw_stable_s)
    );

    debounce_cell #(.W(BTN_W), .DB_SAMPLES(DB_SAMPLES)) u_btn_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick_s),
        .raw    (btn_in),
        .stable (btn_stable_s)
    );

    assign win_s   = in_window(bus.addr, BASE_ADDR);
    assign off_s   = bus.addr[3:2];
    assign rise_s  = btn_stable_s & ~btn_prev_r;
    assign clear_s = (bus.we && win_s && (off_s == OFF_PRESS)) ? bus.data[BTN_W-1:0] : {BTN_W{1'b0}};

    // Edge-detect debounced buttons; a new press overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_r <= '0;
            press_r    <= '0;
        end else begin
            btn_prev_r <= btn_stable_s;
            press_r    <= (press_r & ~clear_s) | rise_s;
        end
    end

    // Read mux: all sources are registered state, so the path is addr-to-rdata only.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (win_s) begin
            case (off_s)
                OFF_SW:    rdata_s = {8'h00, sw_stable_s};
                OFF_BTN:   rdata_s = {27'h000_0000, btn_stable_s};
                OFF_PRESS: rdata_s = {27'h000_0000, press_r};
                default:   rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.rdata = rdata_s;
    assign unused_s  = ^{bus.addr[1:0], bus.data[31:BTN_W]};

endmodule

// File: tb/tb_interface_switch_reader.sv
// Directed bench for interface_switch_reader with TICK_DIV = 4 and DB_SAMPLES = 3.
module tb_interface_switch_reader;
    import iface_pkg::*;

    localparam logic [31:0] BASE = SW_BASE_ADDR;

    logic             clk;
    logic             rst_n;
    logic [SW_W-1:0]  sw_in;
    logic [BTN_W-1:0] btn_in;
    int               checks;
    int               errors;

    interface_switch_reader_if bus ();

    interface_switch_reader #(
        .BASE_ADDR  (BASE),
        .TICK_DIV   (4),
        .DB_SAMPLES (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .sw_in  (sw_in),
        .btn_in (btn_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        v = bus.rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.data = d;
        @(negedge clk);
        bus.we   = 1'b0;
        bus.data = 32'h0000_0000;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst_n  = 1'b0;
        sw_in  = 24'hFF_FFFF;
        btn_in = 5'b00000;
        cyc(3);
        for (int a = 0; a < 4; a++) begin
            rd(BASE + 32'(a * 4), v);
            checks++;
            if (v !== 32'h0000_0000) begin
                errors++;
                $display("FAIL reset_read off=%0d got %h expected %h", a, v, 32'h0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(14);
        rd(BASE, v);
        checks++;
        if (v !== 32'h00FF_FFFF) begin
            errors++;
            $display("FAIL reset_release_sw got %h expected %h", v, 32'h00FF_FFFF);
        end
    endtask

    task automatic test_levels;
        logic [31:0] v;
        sw_in = 24'hA5_A5A5;
        cyc(20);
        rd(BASE, v);
        checks++;
        if (v !== 32'h00A5_A5A5) begin
            errors++;
            $display("FAIL sw_pattern got %h expected %h", v, 32'h00A5_A5A5);
        end
        sw_in = 24'h00_0000;
        cyc(20);
        rd(BASE, v);
        checks++;
        if (v !== 32'h0000_0000) begin
            errors++;
            $display("FAIL sw_zero got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_glitch;
        logic [31:0] v;
        logic        saw_one;
        saw_one = 1'b0;
        sw_in[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd(BASE, v);
            if (v[0]) saw_one = 1'b1;
        end
        sw_in[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd(BASE, v);
            if (v[0]) saw_one = 1'b1;
        end
        checks++;
        if (saw_one !== 1'b0) begin
            errors++;
            $display("FAIL glitch_2tick got %b expected %b", saw_one, 1'b0);
        end
        sw_in[0] = 1'b1;
        cyc(12);
        sw_in[0] = 1'b0;
        cyc(3);
        rd(BASE, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL pulse_3tick got %h expected %h", v, 32'h1);
        end
        cyc(14);
        rd(BASE, v);
        checks++;
        if (v !== 32'h0000_0000) begin
            errors++;
            $display("FAIL pulse_release got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic press_bit2;
        btn_in = 5'b00100;
        cyc(16);
        btn_in = 5'b00000;
        cyc(16);
    endtask

    task automatic test_press_sticky;
        logic [31:0] v;
        btn_in = 5'b00100;
        cyc(16);
        rd(BASE + 32'h4, v);
        checks++;
        if (v !== 32'h0000_0004) begin
            errors++;
            $display("FAIL btn_held got %h expected %h", v, 32'h4);
        end
        btn_in = 5'b00000;
        cyc(16);
        rd(BASE + 32'h4, v);
        checks++;
        if (v !== 32'h0000_0000) begin
            errors++;
            $display("FAIL btn_released got %h expected %h", v, 32'h0);
        end
        rd(BASE + 32'h8, v);
        checks++;
        if (v !== 32'h0000_0004) begin
            errors++;
            $display("FAIL press_sticky got %h expected %h", v, 32'h4);
        end
    endtask

    task automatic test_clear;
        logic [31:0] v;
        wr(BASE + 32'h8, 32'h0000_0004);
        rd(BASE + 32'h8, v);
        checks++;
        if (v !== 32'h0000_0000) begin
            errors++;
            $display("FAIL clear_bit2 got %h expected %h", v, 32'h0);
        end
        press_bit2();
        wr(BASE + 32'h8, 32'h0000_0001);
        rd(BASE + 32'h8, v);
        checks++;
        if (v !== 32'h0000_0004) begin
            errors++;
            $display("FAIL clear_other_bit got %h expected %h", v, 32'h4);
        end
        // Writes outside the PRESS register must not clear flags.
        wr(BASE + 32'h18, 32'hFFFF_FFFF);
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rd(BASE + 32'h8, v);
        checks++;
        if (v !== 32'h0000_0004) begin
            errors++;
            $display("FAIL clear_misdecode got %h expected %h", v, 32'h4);
        end
        wr(BASE + 32'h8, 32'hFFFF_FFFF);
        rd(BASE + 32'h8, v);
        checks++;
        if (v !== 32'h0000_0000) begin
            errors++;
            $display("FAIL clear_all got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] v;
        logic        hit;
        hit = 1'b0;
        btn_in = 5'b01000;
        for (int i = 0; i < 40; i++) begin
            if (!hit) begin
                @(negedge clk);
                rd(BASE + 32'h4, v);
                if (v[3]) begin
                    hit = 1'b1;
                    bus.we   = 1'b1;
                    bus.addr = BASE + 32'h8;
                    bus.data = 32'h0000_0008;
                    @(negedge clk);
                    bus.we   = 1'b0;
                    bus.data = 32'h0000_0000;
                end
            end
        end
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL simul_timeout got %b expected %b", hit, 1'b1);
        end
        rd(BASE + 32'h8, v);
        checks++;
        if (v !== 32'h0000_0008) begin
            errors++;
            $display("FAIL simul_set_wins got %h expected %h", v, 32'h8);
        end
        btn_in = 5'b00000;
        cyc(16);
        wr(BASE + 32'h8, 32'h0000_001F);
    endtask

    task automatic test_decode;
        logic [31:0] v;
        sw_in = 24'h12_3456;
        cyc(20);
        press_bit2();
        rd(BASE + 32'hC, v);
        checks++;
        if (v !== 32'h0000_0000) begin
            errors++;
            $display("FAIL read_0xC got %h expected %h", v, 32'h0);
        end
        rd(BASE + 32'h10, v);
        checks++;
        if (v !== 32'h0000_0000) begin
            errors++;
            $display("FAIL read_outside got %h expected %h", v, 32'h0);
        end
        rd(BASE + 32'h18, v);
        checks++;
        if (v !== 32'h0000_0000) begin
            errors++;
            $display("FAIL read_outside_press got %h expected %h", v, 32'h0);
        end
        wr(BASE, 32'hFFFF_FFFF);
        rd(BASE, v);
        checks++;
        if (v !== 32'h0012_3456) begin
            errors++;
            $display("FAIL write_sw_ignored got %h expected %h", v, 32'h0012_3456);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        bus.we   = 1'b0;
        bus.addr = 32'h0000_0000;
        bus.data = 32'h0000_0000;
        test_reset();
        test_levels();
        test_glitch();
        test_press_sticky();
        test_clear();
        test_simultaneous();
        test_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
